// File: rtl/vram_scanout_reader.sv
// vram_scanout_reader: scans one RGB888 frame out of VRAM port B and streams packed pixels with SOF/EOL/EOF markers.
module vram_scanout_reader #(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 18
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FRAME_START,
  output logic [ADDR_W-1:0] ADDR_B,
  output logic              WE_B,
  output logic [7:0]        DATA_B,
  input  logic [7:0]        Q_B,
  output logic [23:0]       PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              PIX_SOF,
  output logic              PIX_EOL,
  output logic              PIX_EOF,
  output logic              BUSY
);
  localparam int XW = H_RES > 1 ? $clog2(H_RES) : 1;
  localparam int YW = V_RES > 1 ? $clog2(V_RES) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, OUT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0] r_q, r_d, g_q, g_d;
  logic [23:0] pix_q, pix_d;
  logic valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, busy_q, busy_d;
  logic x_last, y_last;
  assign x_last = x_q == X_LAST;
  assign y_last = y_q == Y_LAST;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    g_d     = g_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (FRAME_START) begin
        addr_d  = BASE;
        x_d     = '0;
        y_d     = '0;
        busy_d  = 1'b1;
        state_d = F0;
      end
      F0: begin
        addr_d  = addr_q + 1'b1;
        state_d = F1;
      end
      F1: begin
        r_d     = Q_B;
        addr_d  = addr_q + 1'b1;
        state_d = F2;
      end
      F2: begin
        g_d     = Q_B;
        state_d = F3;
      end
      F3: begin
        pix_d   = {r_q, g_q, Q_B};
        valid_d = 1'b1;
        sof_d   = x_q == '0 && y_q == '0;
        eol_d   = x_last;
        eof_d   = x_last && y_last;
        state_d = OUT;
      end
      OUT: if (PIX_READY) begin
        valid_d = 1'b0;
        if (eof_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // ADDR_B still points at the B byte, so +1 is the next pixel's R byte
          addr_d  = addr_q + 1'b1;
          x_d     = x_last ? '0 : x_q + 1'b1;
          y_d     = x_last ? y_q + 1'b1 : y_q;
          state_d = F0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      g_q     <= g_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end
  assign ADDR_B    = addr_q;
  assign WE_B      = 1'b0;
  assign DATA_B    = 8'h00;
  assign PIX_DATA  = pix_q;
  assign PIX_VALID = valid_q;
  assign PIX_SOF   = sof_q;
  assign PIX_EOL   = eol_q;
  assign PIX_EOF   = eof_q;
  assign BUSY      = busy_q;
endmodule

// File: tb/tb_vram_scanout_reader.sv
// tb_vram_scanout_reader: directed bench on a 4x3 frame at byte base 6 with a 1-cycle-latency VRAM model.
module tb_vram_scanout_reader;
  localparam int H = 4, V = 3, BASE = 6, AW = 8, NPIX = H * V;
  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, pix_ready = 1'b0;
  logic [AW-1:0] addr_b;
  logic we_b;
  logic [7:0] data_b, q_b;
  logic [23:0] pix_data;
  logic pix_valid, sof, eol, eof, busy;
  logic [7:0] mem [256];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) q_b <= mem[addr_b];

  vram_scanout_reader #(.H_RES(H), .V_RES(V), .BASE_ADDR(BASE), .ADDR_W(AW)) dut (
    .CLK(clk), .RST_N(rst_n), .FRAME_START(frame_start), .ADDR_B(addr_b), .WE_B(we_b),
    .DATA_B(data_b), .Q_B(q_b), .PIX_DATA(pix_data), .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready), .PIX_SOF(sof), .PIX_EOL(eol), .PIX_EOF(eof), .BUSY(busy));

  function automatic logic [23:0] exp_pix(int n);
    return {mem[BASE + 3 * n], mem[BASE + 3 * n + 1], mem[BASE + 3 * n + 2]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pix_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_start = 1'($urandom);
      pix_ready = 1'($urandom);
      tick();
    end
    checks++;
    if ({addr_b, pix_valid, busy, sof, eol, eof, pix_data, we_b, data_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d v=%b busy=%b m=%b%b%b data=%h we=%b wd=%h want all zero",
               addr_b, pix_valid, busy, sof, eol, eof, pix_data, we_b, data_b);
    end
    frame_start = 1'b0;
    pix_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, pix_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b want 0 0", busy, pix_valid);
    end
  endtask

  task automatic test_single_pixel;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (addr_b !== 8'(BASE) || busy !== 1'b1) begin
      errors++;
      $display("FAIL addr_c1: got addr=%0d busy=%b want %0d 1", addr_b, busy, BASE);
    end
    tick();
    checks++;
    if (addr_b !== 8'(BASE + 1)) begin
      errors++;
      $display("FAIL addr_c2: got %0d want %0d", addr_b, BASE + 1);
    end
    tick();
    checks++;
    if (addr_b !== 8'(BASE + 2)) begin
      errors++;
      $display("FAIL addr_c3: got %0d want %0d", addr_b, BASE + 2);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_c4: got %b want 0", pix_valid);
    end
    tick();
    checks++;
    if ({pix_valid, pix_data, sof, eol, eof} !== {1'b1, 24'h112233, 3'b100}) begin
      errors++;
      $display("FAIL pixel0_c5: got v=%b data=%h sof/eol/eof=%b%b%b want 1 112233 100", pix_valid, pix_data, sof, eol, eof);
    end
  endtask

  task automatic test_backpressure;
    pix_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({pix_valid, pix_data, sof, eol, eof} !== {1'b1, 24'h112233, 3'b100}) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b data=%h m=%b%b%b want 1 112233 100", i, pix_valid, pix_data, sof, eol, eof);
      end
    end
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || addr_b !== 8'(BASE + 3)) begin
      errors++;
      $display("FAIL after_handshake: got v=%b addr=%0d want 0 %0d", pix_valid, addr_b, BASE + 3);
    end
  endtask

  task automatic test_frame;
    int n = 1;
    int max_addr = 0;
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (int'(addr_b) > max_addr) max_addr = int'(addr_b);
      frame_start = 1'b0;
      if (pix_valid) begin
        pix_ready = eof ? 1'b1 : ($urandom_range(0, 9) < 7);
        if (pix_ready) begin
          checks++;
          if ({pix_data, sof, eol, eof} !== {exp_pix(n), n == 0, (n % H) == H - 1, n == NPIX - 1}) begin
            errors++;
            $display("FAIL pixel_%0d: got data=%h m=%b%b%b want %h %b%b%b", n, pix_data, sof, eol, eof,
                     exp_pix(n), n == 0, (n % H) == H - 1, n == NPIX - 1);
          end
          if (eof) begin
            frame_start = 1'b1;
            done = 1'b1;
          end
          n++;
        end
      end else begin
        pix_ready = 1'($urandom_range(0, 1));
        frame_start = $urandom_range(0, 5) == 0;
      end
      tick();
    end
    frame_start = 1'b0;
    pix_ready = 1'b0;
    checks++;
    if (!done || n != NPIX) begin
      errors++;
      $display("FAIL frame_count: got %0d pixels want %0d", n, NPIX);
    end
    checks++;
    if (max_addr != BASE + 3 * NPIX - 1) begin
      errors++;
      $display("FAIL max_addr: got %0d want %0d", max_addr, BASE + 3 * NPIX - 1);
    end
    checks++;
    if ({busy, pix_valid} !== 2'b00) begin
      errors++;
      $display("FAIL busy_after_eof: got busy=%b valid=%b want 0 0", busy, pix_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({busy, pix_valid} !== 2'b00 || addr_b !== 8'(BASE + 3 * NPIX - 1)) begin
        errors++;
        $display("FAIL no_restart_%0d: got busy=%b valid=%b addr=%0d want 0 0 %0d", i, busy, pix_valid, addr_b,
                 BASE + 3 * NPIX - 1);
      end
    end
  endtask

  task automatic test_restart;
    bit ok;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (addr_b !== 8'(BASE) || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_addr: got addr=%0d busy=%b want %0d 1", addr_b, busy, BASE);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pix_data !== exp_pix(0) || sof !== 1'b1) begin
      errors++;
      $display("FAIL restart_pixel: got seen=%b data=%h sof=%b want 1 %h 1", ok, pix_data, sof, exp_pix(0));
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    int n = 0;
    pix_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (pix_valid && n == 5) break;
      if (pix_valid) n++;
      tick();
    end
    checks++;
    if (n != 5 || pix_valid !== 1'b1 || pix_data !== exp_pix(5)) begin
      errors++;
      $display("FAIL reach_pixel5: got n=%0d v=%b data=%h want 5 1 %h", n, pix_valid, pix_data, exp_pix(5));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({addr_b, pix_valid, busy, sof, eol, eof, pix_data} !== '0) begin
      errors++;
      $display("FAIL async_reset: got addr=%0d v=%b busy=%b m=%b%b%b data=%h want all zero",
               addr_b, pix_valid, busy, sof, eol, eof, pix_data);
    end
    tick();
    rst_n = 1'b1;
    pix_ready = 1'b0;
    tick();
    checks++;
    if ({busy, pix_valid} !== 2'b00) begin
      errors++;
      $display("FAIL no_resume: got busy=%b valid=%b want 0 0", busy, pix_valid);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (addr_b !== 8'(BASE)) begin
      errors++;
      $display("FAIL post_reset_addr: got %0d want %0d", addr_b, BASE);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pix_data !== exp_pix(0) || {sof, eol, eof} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_pixel: got seen=%b data=%h m=%b%b%b want 1 %h 100", ok, pix_data, sof, eol, eof, exp_pix(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
    mem[BASE] = 8'h11;
    mem[BASE + 1] = 8'h22;
    mem[BASE + 2] = 8'h33;
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_frame();
    test_restart();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
